// File: rtl/hash_result_scanner.sv
// Post-processing scanner for the hash core: streams back one H0 word per nonce, tracks the
// minimum hash and the first nonce under target, then writes a 2-word summary to memory.
module hash_result_scanner #(
    parameter int unsigned NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] result_addr,
    input  logic [15:0] report_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [7:0]  first_nonce,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned CNT_W = 9;

    typedef enum logic [2:0] {IDLE, READ, WR0, WR1, DONE} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   issue_cnt, issue_d;
    logic [CNT_W-1:0]   cmp_cnt, cmp_d;
    logic               primed, primed_d;
    logic [15:0]        base_addr, base_d;
    logic [15:0]        rpt_addr, rpt_d;
    logic [31:0]        tgt, tgt_d;
    logic               done_d, found_d, we_d;
    logic [7:0]         first_d, bestn_d;
    logic [31:0]        besth_d, wdata_d;
    logic [15:0]        addr_d;
    logic               accept_c;

    assign mem_clk  = clk;
    assign accept_c = start && ((state == IDLE) || (state == DONE));

    // Next-state and datapath update.
    always_comb begin
        state_d  = state;
        issue_d  = issue_cnt;
        cmp_d    = cmp_cnt;
        primed_d = primed;
        base_d   = base_addr;
        rpt_d    = rpt_addr;
        tgt_d    = tgt;
        done_d   = done;
        found_d  = found;
        first_d  = first_nonce;
        bestn_d  = best_nonce;
        besth_d  = best_hash;
        we_d     = mem_we;
        addr_d   = mem_addr;
        wdata_d  = mem_write_data;

        unique case (state)
            READ: begin
                if (issue_cnt < CNT_W'(NUM_NONCES)) begin
                    addr_d  = base_addr + 16'(issue_cnt);
                    issue_d = issue_cnt + CNT_W'(1);
                end
                // First READ edge only waits out the two-cycle memory read latency.
                if (!primed) begin
                    primed_d = 1'b1;
                end else begin
                    if (mem_read_data < best_hash) begin
                        besth_d = mem_read_data;
                        bestn_d = cmp_cnt[7:0];
                    end
                    if ((mem_read_data < tgt) && !found) begin
                        found_d = 1'b1;
                        first_d = cmp_cnt[7:0];
                    end
                    cmp_d = cmp_cnt + CNT_W'(1);
                    if (cmp_cnt == CNT_W'(NUM_NONCES - 1)) begin
                        state_d = WR0;
                    end
                end
            end
            WR0: begin
                we_d    = 1'b1;
                addr_d  = rpt_addr;
                wdata_d = {found, 15'b0, first_nonce, best_nonce};
                state_d = WR1;
            end
            WR1: begin
                addr_d  = rpt_addr + 16'd1;
                wdata_d = best_hash;
                state_d = DONE;
            end
            DONE: begin
                we_d   = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase

        if (accept_c) begin
            state_d  = READ;
            addr_d   = result_addr;
            we_d     = 1'b0;
            done_d   = 1'b0;
            found_d  = 1'b0;
            besth_d  = 32'hFFFF_FFFF;
            bestn_d  = 8'd0;
            first_d  = 8'd0;
            issue_d  = CNT_W'(1);
            cmp_d    = '0;
            primed_d = 1'b0;
            base_d   = result_addr;
            rpt_d    = report_addr;
            tgt_d    = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            issue_cnt      <= '0;
            cmp_cnt        <= '0;
            primed         <= 1'b0;
            base_addr      <= '0;
            rpt_addr       <= '0;
            tgt            <= '0;
            done           <= 1'b0;
            found          <= 1'b0;
            first_nonce    <= '0;
            best_nonce     <= '0;
            best_hash      <= 32'hFFFF_FFFF;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            state          <= state_d;
            issue_cnt      <= issue_d;
            cmp_cnt        <= cmp_d;
            primed         <= primed_d;
            base_addr      <= base_d;
            rpt_addr       <= rpt_d;
            tgt            <= tgt_d;
            done           <= done_d;
            found          <= found_d;
            first_nonce    <= first_d;
            best_nonce     <= bestn_d;
            best_hash      <= besth_d;
            mem_we         <= we_d;
            mem_addr       <= addr_d;
            mem_write_data <= wdata_d;
        end
    end

endmodule

// File: tb/tb_hash_result_scanner.sv
// Directed bench for hash_result_scanner with a synchronous single-port memory model.
module tb_hash_result_scanner;

    localparam int unsigned N = 16;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] result_addr, report_addr;
    logic [31:0] target;
    logic        done, found, mem_clk, mem_we;
    logic [7:0]  first_nonce, best_nonce;
    logic [31:0] best_hash, mem_write_data, mem_read_data;
    logic [15:0] mem_addr;

    logic [31:0] mem [0:65535];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          we_cnt;
    logic [15:0] wr_a [0:1];
    logic        oob;
    logic        mon_clr  = 1'b0;
    logic        win_en   = 1'b0;
    logic [15:0] ra_cur   = '0;
    logic [15:0] rep_cur  = '0;
    int          lat;
    bit          dropped;

    hash_result_scanner #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .result_addr(result_addr), .report_addr(report_addr), .target(target),
        .done(done), .found(found), .first_nonce(first_nonce), .best_nonce(best_nonce),
        .best_hash(best_hash), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    // Write log and address-window monitor.
    always @(posedge clk) begin
        logic [15:0] off;
        cyc <= cyc + 1;
        off = mem_addr - ra_cur;
        if (mon_clr) begin
            we_cnt <= 0;
            oob    <= 1'b0;
        end else begin
            if (mem_we) begin
                if (we_cnt < 2) wr_a[we_cnt] <= mem_addr;
                we_cnt <= we_cnt + 1;
            end
            if (win_en && !(off < 16'(N) || mem_addr == rep_cur ||
                            mem_addr == rep_cur + 16'd1))
                oob <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_scan(input logic [15:0] ra, input logic [15:0] rep, input logic [31:0] tg,
                            input int p1, input int p2, output int l, output bit dr);
        result_addr = ra;
        report_addr = rep;
        target      = tg;
        ra_cur      = ra;
        rep_cur     = rep;
        mem[rep]    = 32'hDEAD_BEEF;
        mem[rep + 16'd1] = 32'hDEAD_BEEF;
        @(negedge clk) mon_clr = 1'b1;
        @(negedge clk) begin mon_clr = 1'b0; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        dr     = !done;
        win_en = 1'b1;
        l      = -1;
        for (int k = 1; k <= 60; k++) begin
            start = (k == p1) || (k == p2);
            @(negedge clk);
            if (done) begin
                l = k;
                break;
            end
        end
        start  = 1'b0;
        win_en = 1'b0;
    endtask

    task automatic check_scan(input string tg, input logic [15:0] rep, input logic f,
                              input logic [7:0] fn, input logic [7:0] bn, input logic [31:0] bh);
        chk({tg, "_latency"}, 32'(lat), 32'd20);
        chk({tg, "_found"}, 32'(found), 32'(f));
        chk({tg, "_first_nonce"}, 32'(first_nonce), 32'(fn));
        chk({tg, "_best_nonce"}, 32'(best_nonce), 32'(bn));
        chk({tg, "_best_hash"}, best_hash, bh);
        chk({tg, "_summary0"}, mem[rep], {f, 15'b0, fn, bn});
        chk({tg, "_summary1"}, mem[rep + 16'd1], bh);
        chk({tg, "_we_cycles"}, 32'(we_cnt), 32'd2);
        chk({tg, "_wr_addr0"}, 32'(wr_a[0]), 32'(rep));
        chk({tg, "_wr_addr1"}, 32'(wr_a[1]), 32'(rep + 16'd1));
        chk({tg, "_addr_window"}, 32'(oob), 32'd0);
        chk({tg, "_we_idle"}, 32'(mem_we), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        result_addr = '0; report_addr = '0; target = '0;
        for (int i = 0; i < int'(N); i++) begin
            mem[16'h0100 + 16'(i)] = 32'h8000_0000 - 32'(i);
            mem[16'h0200 + 16'(i)] = 32'h0000_1234;
            mem[16'hFFF8 + 16'(i)] = 32'hA000_0000;
            mem[16'h0380 + 16'(i)] = 32'hFFFF_FFFF;
        end
        mem[16'hFFFB] = 32'h3000_0000;
        mem[16'h0001] = 32'h1000_0000;
        mem[16'h0004] = 32'h1000_0000;

        mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        mon_clr = 1'b0;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_first_nonce", 32'(first_nonce), 32'd0);
        chk("rst_best_nonce", 32'(best_nonce), 32'd0);
        chk("rst_best_hash", best_hash, 32'hFFFF_FFFF);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Descending words; word 10 equals target exactly and must not pass.
        run_scan(16'h0100, 16'h0180, 32'h7FFF_FFF6, 0, 0, lat, dropped);
        check_scan("desc", 16'h0180, 1'b1, 8'd11, 8'd15, 32'h7FFF_FFF1);

        run_scan(16'h0200, 16'h0280, 32'h0000_0000, 0, 0, lat, dropped);
        check_scan("tgt0", 16'h0280, 1'b0, 8'd0, 8'd0, 32'h0000_1234);

        // Window wraps FFF8..0007; tie at index 12 keeps index 9.
        run_scan(16'hFFF8, 16'h0300, 32'h4000_0000, 0, 0, lat, dropped);
        check_scan("wrap", 16'h0300, 1'b1, 8'd3, 8'd9, 32'h1000_0000);

        run_scan(16'h0380, 16'h03C0, 32'hFFFF_FFFF, 0, 0, lat, dropped);
        check_scan("allff", 16'h03C0, 1'b0, 8'd0, 8'd0, 32'hFFFF_FFFF);

        // Reset at E0+8 aborts the scan without any summary write.
        result_addr = 16'h0100; report_addr = 16'h0400; target = 32'h7FFF_FFF6;
        mem[16'h0400] = 32'hDEAD_BEEF;
        @(negedge clk) mon_clr = 1'b1;
        @(negedge clk) begin mon_clr = 1'b0; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_best_hash", best_hash, 32'hFFFF_FFFF);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_write", 32'(we_cnt), 32'd0);
        chk("abort_report_kept", mem[16'h0400], 32'hDEAD_BEEF);
        chk("abort_idle_done", 32'(done), 32'd0);
        run_scan(16'h0100, 16'h0400, 32'h7FFF_FFF6, 0, 0, lat, dropped);
        check_scan("fresh", 16'h0400, 1'b1, 8'd11, 8'd15, 32'h7FFF_FFF1);

        // Start pulses in READ (E0+5) and WR1 (E0+19) are ignored.
        run_scan(16'hFFF8, 16'h0500, 32'h4000_0000, 5, 19, lat, dropped);
        check_scan("repulse", 16'h0500, 1'b1, 8'd3, 8'd9, 32'h1000_0000);

        // Start accepted from DONE: done drops on the next edge.
        run_scan(16'h0200, 16'h0600, 32'h0000_0000, 0, 0, lat, dropped);
        chk("restart_done_drop", 32'(dropped), 32'd1);
        check_scan("restart", 16'h0600, 1'b0, 8'd0, 8'd0, 32'h0000_1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
